// File: rtl/prach_ditfft3_bf3p.sv
// prach_ditfft3_bf3p
// Radix-3 DIT butterfly stage for the PRACH FFT path. A group is 3*STRIDE
// valid samples: x0[k], then x1[k], then x2[k] (k = 0..STRIDE-1). Per group
// the block emits x0[k], x1[k]+x2[k], x1[k]-x2[k] in the same block order.
// Every result lags its own sample slot by STRIDE valid samples. The output
// is registered two clocks after din_dv.
//
// Ports
//   clk                input   rising-edge clock
//   rst_n              input   synchronous active-low reset
//   din_dr, din_di     input   sample real/imag, signed DW
//   din_dv             input   sample valid
//   sync_in            input   first sample of a group (x0[0]), qualified by din_dv
//   dout_dr, dout_di   output  result real/imag, signed DW
//   dout_dv            output  result valid (din_dv delayed 2 clk)
//   sync_out           output  beat carrying x0[0] of the latest synced group
//   ovf                output  sum/diff on this beat did not fit DW bits
module prach_ditfft3_bf3p #(
  parameter int DW     = 18,
  parameter int STRIDE = 1,
  parameter int SAT    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] din_dr,
  input  logic signed [DW-1:0] din_di,
  input  logic                 din_dv,
  input  logic                 sync_in,
  output logic signed [DW-1:0] dout_dr,
  output logic signed [DW-1:0] dout_di,
  output logic                 dout_dv,
  output logic                 sync_out,
  output logic                 ovf
);

  // The buffer is rounded up to a power of two so that the k index covers it
  // exactly. Entries at STRIDE and above are never addressed.
  localparam int KW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int DEPTH = 1 << KW;
  localparam logic [KW-1:0] K_LAST = KW'(STRIDE - 1);

  // ---------------------------------------------------------------------------
  // Position state (phase 0..2, index k)
  // ---------------------------------------------------------------------------
  logic [1:0]    phase_q, ph_d, cur_ph;
  logic [KW-1:0] k_q, k_d, cur_k;

  // A qualified sync forces the current sample to slot (0,0).
  always_comb begin
    cur_ph = sync_in ? 2'd0 : phase_q;
    cur_k  = sync_in ? '0   : k_q;
  end

  always_comb begin
    ph_d = phase_q;
    k_d  = k_q;
    if (din_dv) begin
      if (cur_k == K_LAST) begin
        k_d  = '0;
        ph_d = (cur_ph == 2'd2) ? 2'd0 : cur_ph + 2'd1;
      end else begin
        k_d  = cur_k + KW'(1);
        ph_d = cur_ph;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= 2'd0;
      k_q     <= '0;
    end else begin
      phase_q <= ph_d;
      k_q     <= k_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot buffer. Each entry holds the x0, the x1 or the finished difference of
  // slot k, depending on the phase. mem_o keeps the overflow of a stored
  // difference so that the flag leaves with the beat that carries it.
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0] mem_r [DEPTH];
  logic signed [DW-1:0] mem_i [DEPTH];
  logic                 mem_o [DEPTH];

  logic signed [DW-1:0] rd_r, rd_i;
  logic                 rd_o;

  always_comb begin
    rd_r = mem_r[cur_k];
    rd_i = mem_i[cur_k];
    rd_o = mem_o[cur_k];
  end

  // ---------------------------------------------------------------------------
  // Butterfly arithmetic at DW+1 bits (rd = x1, din = x2 during phase 2)
  // ---------------------------------------------------------------------------
  function automatic logic signed [DW-1:0] fit(input logic signed [DW:0] v);
    if (v[DW] == v[DW-1] || SAT == 0) return v[DW-1:0];
    return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction

  function automatic logic oflow(input logic signed [DW:0] v);
    return v[DW] ^ v[DW-1];
  endfunction

  logic signed [DW:0] sum_r, sum_i, dif_r, dif_i;

  always_comb begin
    sum_r = (DW+1)'(rd_r) + (DW+1)'(din_dr);
    sum_i = (DW+1)'(rd_i) + (DW+1)'(din_di);
    dif_r = (DW+1)'(rd_r) - (DW+1)'(din_dr);
    dif_i = (DW+1)'(rd_i) - (DW+1)'(din_di);
  end

  // ---------------------------------------------------------------------------
  // Result select and buffer write data
  // phase 0: emit stored diff, store x0
  // phase 1: emit stored x0,   store x1
  // phase 2: emit sum,         store diff
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0] res_r, res_i, wr_r, wr_i;
  logic                 res_o, wr_o;

  always_comb begin
    res_r = rd_r;
    res_i = rd_i;
    res_o = rd_o;
    wr_r  = din_dr;
    wr_i  = din_di;
    wr_o  = 1'b0;
    case (cur_ph)
      2'd1: res_o = 1'b0;
      2'd2: begin
        res_r = fit(sum_r);
        res_i = fit(sum_i);
        res_o = oflow(sum_r) | oflow(sum_i);
        wr_r  = fit(dif_r);
        wr_i  = fit(dif_i);
        wr_o  = oflow(dif_r) | oflow(dif_i);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_r[j] <= '0;
        mem_i[j] <= '0;
        mem_o[j] <= 1'b0;
      end
    end else if (din_dv) begin
      mem_r[cur_k] <= wr_r;
      mem_i[cur_k] <= wr_i;
      mem_o[cur_k] <= wr_o;
    end
  end

  // ---------------------------------------------------------------------------
  // Sync tracking. A qualified sync arms the flag. The flag fires on the x0[0]
  // output slot (phase 1, k 0), which comes STRIDE valid samples later. A newer
  // sync resets the position, so it restarts that delay by itself.
  // ---------------------------------------------------------------------------
  logic pend_q, emit_sync;

  always_comb emit_sync = pend_q && (cur_ph == 2'd1) && (cur_k == '0);

  always_ff @(posedge clk) begin
    if (!rst_n)                   pend_q <= 1'b0;
    else if (din_dv && sync_in)   pend_q <= 1'b1;
    else if (din_dv && emit_sync) pend_q <= 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Two-stage output pipeline. The data registers load only on valid beats.
  // ---------------------------------------------------------------------------
  logic [2:1]           vld_pipe;
  logic signed [DW-1:0] s1_dr, s1_di;
  logic                 s1_ovf, s1_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_dr    <= '0;
      s1_di    <= '0;
      s1_ovf   <= 1'b0;
      s1_sync  <= 1'b0;
      dout_dr  <= '0;
      dout_di  <= '0;
      ovf      <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[1], din_dv};
      s1_ovf   <= din_dv & res_o;
      s1_sync  <= din_dv & emit_sync;
      if (din_dv) begin
        s1_dr <= res_r;
        s1_di <= res_i;
      end
      ovf      <= s1_ovf;
      sync_out <= s1_sync;
      if (vld_pipe[1]) begin
        dout_dr <= s1_dr;
        dout_di <= s1_di;
      end
    end
  end

  assign dout_dv = vld_pipe[2];

endmodule

// File: tb/tb_prach_ditfft3_bf3p.sv
// Bench for prach_ditfft3_bf3p. Five instances share one input stream. Their
// configurations are: (S=1 wrap), (S=1 sat), (S=2 wrap), (S=3 wrap), (S=4 sat).
// Each instance is checked against a group-level reference model. The model
// keeps the valid samples seen since the last sync/reset and derives each
// result from the group and slot formulas.
module tb_prach_ditfft3_bf3p;

  localparam int N  = 5;
  localparam int DW = 18;
  localparam int MAXV = 131071;
  localparam int MINV = -131072;

  function automatic int s_of(int i);
    case (i)
      0, 1:    return 1;
      2:       return 2;
      3:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int sat_of(int i);
    return (i == 1 || i == 4) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  logic signed [DW-1:0] din_dr, din_di;
  logic din_dv, sync_in;

  logic signed [DW-1:0] o_dr [N];
  logic signed [DW-1:0] o_di [N];
  logic o_dv [N];
  logic o_sy [N];
  logic o_ov [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    prach_ditfft3_bf3p #(.DW(DW), .STRIDE(s_of(g)), .SAT(sat_of(g))) u_dut (
      .clk(clk), .rst_n(rst_n),
      .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv), .sync_in(sync_in),
      .dout_dr(o_dr[g]), .dout_di(o_di[g]), .dout_dv(o_dv[g]),
      .sync_out(o_sy[g]), .ovf(o_ov[g])
    );
  end

  typedef struct {
    bit dv, sy, ov, chk;
    int dr, di;
  } exp_t;

  exp_t e1 [N];
  exp_t e2 [N];
  int   hr[$], hi[$];
  bit   start_sync, clean;
  int   since_rst;
  int   nchk = 0, nerr = 0;

  task automatic chk(string tag, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reduce a full-precision result to DW bits (wrap or clamp) and flag overflow.
  function automatic int fitv(int s, int sat, output bit o);
    o = (s < MINV) || (s > MAXV);
    if (!o) return s;
    if (sat != 0) return (s < MINV) ? MINV : MAXV;
    return (((s - MINV) % 262144) + 262144) % 262144 + MINV;
  endfunction

  // Expected result for the n-th valid sample of the current epoch.
  function automatic exp_t model(int s, int sat, int n);
    exp_t e;
    int g, r, ph, k, b;
    bit o1, o2;
    g  = n / (3*s);
    r  = n % (3*s);
    ph = r / s;
    k  = r % s;
    e  = '{dv: 1'b1, sy: 1'b0, ov: 1'b0, chk: 1'b1, dr: 0, di: 0};
    if (ph == 1) begin
      b    = g*3*s;
      e.dr = hr[b+k];
      e.di = hi[b+k];
      e.sy = start_sync && g == 0 && k == 0;
    end else if (ph == 2) begin
      b    = g*3*s;
      e.dr = fitv(hr[b+s+k] + hr[n], sat, o1);
      e.di = fitv(hi[b+s+k] + hi[n], sat, o2);
      e.ov = o1 | o2;
    end else if (g > 0) begin
      b    = (g-1)*3*s;
      e.dr = fitv(hr[b+s+k] - hr[b+2*s+k], sat, o1);
      e.di = fitv(hi[b+s+k] - hi[b+2*s+k], sat, o2);
      e.ov = o1 | o2;
    end else begin
      // First-group x0 slots show earlier buffer contents. After reset those
      // are known zeros. After a resync they are leftovers of the previous group.
      e.chk = clean;
    end
    return e;
  endfunction

  // Update the model for the posedge that is about to sample the current inputs.
  task automatic model_step();
    int n;
    if (!rst_n) begin
      hr.delete(); hi.delete();
      start_sync = 1'b0; clean = 1'b1; since_rst = 0;
      for (int i = 0; i < N; i++) begin
        e1[i] = '{dv: 1'b0, sy: 1'b0, ov: 1'b0, chk: 1'b1, dr: 0, di: 0};
        e2[i] = e1[i];
      end
    end else begin
      for (int i = 0; i < N; i++) e2[i] = e1[i];
      if (din_dv) begin
        if (sync_in) begin
          hr.delete(); hi.delete();
          start_sync = 1'b1;
          clean      = (since_rst == 0);
        end
        hr.push_back(int'(din_dr));
        hi.push_back(int'(din_di));
        n = hr.size() - 1;
        since_rst++;
        for (int i = 0; i < N; i++) e1[i] = model(s_of(i), sat_of(i), n);
      end else begin
        for (int i = 0; i < N; i++)
          e1[i] = '{dv: 1'b0, sy: 1'b0, ov: 1'b0, chk: 1'b0, dr: 0, di: 0};
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d.dv", i), int'(o_dv[i]), int'(e2[i].dv));
      chk($sformatf("u%0d.sync", i), int'(o_sy[i]), int'(e2[i].sy));
      if (e2[i].chk) begin
        chk($sformatf("u%0d.dr", i), int'(o_dr[i]), e2[i].dr);
        chk($sformatf("u%0d.di", i), int'(o_di[i]), e2[i].di);
        chk($sformatf("u%0d.ovf", i), int'(o_ov[i]), int'(e2[i].ov));
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, and check after the edge.
  task automatic step(bit r, bit v, bit sy, int dr, int di);
    rst_n   = r;
    din_dv  = v;
    sync_in = sy;
    din_dr  = DW'(dr);
    din_di  = DW'(di);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(int n);
    for (int j = 0; j < n; j++) step(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  function automatic int rnd_val();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 262143)) + MINV;
    return int'($urandom_range(0, 200)) - 100;
  endfunction

  initial begin
    int v;
    // Reset
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b0, 0, 0);

    // Basic S=1 butterfly, then full-scale sums for wrap vs saturate
    step(1, 1, 1, 5, -3);
    step(1, 1, 0, 100, 7);
    step(1, 1, 0, 40, -2);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, MAXV, 0);
    step(1, 1, 0, MAXV, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, MINV, 5);
    step(1, 1, 0, MINV, -5);
    step(1, 1, 0, 0, 0);
    idle(3);

    // S=4 ramp from a clean buffer
    step(0, 0, 0, 0, 0);
    for (int j = 0; j < 12; j++) begin
      v = (j < 4) ? j + 1 : (j < 8) ? j + 6 : j + 12;
      step(1, 1, j == 0, v, 0);
    end
    for (int j = 0; j < 4; j++) step(1, 1, 0, 0, 0);
    idle(2);

    // Resync in the middle of a group (phase 1 for S=4)
    for (int j = 0; j < 5; j++) step(1, 1, j == 0, rnd_val(), rnd_val());
    for (int j = 0; j < 20; j++) step(1, 1, j == 0, rnd_val(), rnd_val());
    idle(2);

    // Random valid gaps with occasional syncs
    for (int j = 0; j < 400; j++) begin
      bit vv, ss;
      vv = ($urandom_range(0, 1) == 1);
      ss = vv && ($urandom_range(0, 39) == 0);
      step(1, vv, ss, rnd_val(), rnd_val());
    end
    idle(2);

    // Single-cycle reset mid-group with din_dv held high, then resumed input
    for (int j = 0; j < 7; j++) step(1, 1, j == 0, rnd_val(), rnd_val());
    step(0, 1, 0, 77, 77);
    for (int j = 0; j < 15; j++) step(1, 1, 0, rnd_val(), rnd_val());
    for (int j = 0; j < 14; j++) step(1, 1, j == 0, rnd_val(), rnd_val());
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
